// File: rtl/mem_reg_table_v2_pkg.sv
// -----------------------------------------------------------------------------
// mem_reg_pkg
// Shared definitions for the command/status register table:
//   - opcode values decoded from reg_addr[3:0]
//   - top-level FSM state encoding
//   - small elaboration helpers for sizing the byte serialiser
// -----------------------------------------------------------------------------
package mem_reg_pkg;

  localparam logic [3:0] OP_READ  = 4'h7;
  localparam logic [3:0] OP_NUM   = 4'h8;
  localparam logic [3:0] OP_SIZE  = 4'h9;
  localparam logic [3:0] OP_ERASE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_NUM,
    ST_FETCH_SIZE,
    ST_SEND,
    ST_WAIT_READ,
    ST_WAIT_ERASE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold the value n (byte lengths run 1..n).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_reg_table_v2_if.sv
// -----------------------------------------------------------------------------
// mem_reg_table_v2_if
// Bundles every non-clock/reset signal of the register table:
//   SPI side    : reg_addr/reg_data/reg_input_valid in, byte_out/byte_out_valid
//                 out with byte_out_ready flow control
//   memory side : count/size request pulses and valid strobes, read/erase
//                 start pulses and done flags, latched img_index
//   status      : busy, cmd_reject
// Modports: slave = the register table, master = whoever drives it.
// -----------------------------------------------------------------------------
interface mem_reg_table_v2_if #(
  parameter int DATA_W     = 17,
  parameter int IDX_W      = 12,
  parameter int SIZE_BYTES = 3
);
  logic [7:0]              reg_addr;
  logic [DATA_W-1:0]       reg_data;
  logic                    reg_input_valid;
  logic [IDX_W-1:0]        num_both_img;
  logic                    num_both_img_valid;
  logic [8*SIZE_BYTES-1:0] jpg_size;
  logic                    jpg_size_valid;
  logic                    done_reading_img_flag;
  logic                    done_erasing_img_flag;
  logic                    read_num_img;
  logic                    read_img_size;
  logic [IDX_W-1:0]        img_index;
  logic                    start_reading_img_flag;
  logic                    start_erasing_img_flag;
  logic [7:0]              byte_out;
  logic                    byte_out_valid;
  logic                    byte_out_ready;
  logic                    busy;
  logic                    cmd_reject;

  modport slave (
    input  reg_addr, reg_data, reg_input_valid,
    input  num_both_img, num_both_img_valid, jpg_size, jpg_size_valid,
    input  done_reading_img_flag, done_erasing_img_flag, byte_out_ready,
    output read_num_img, read_img_size, img_index,
    output start_reading_img_flag, start_erasing_img_flag,
    output byte_out, byte_out_valid, busy, cmd_reject
  );

  modport master (
    output reg_addr, reg_data, reg_input_valid,
    output num_both_img, num_both_img_valid, jpg_size, jpg_size_valid,
    output done_reading_img_flag, done_erasing_img_flag, byte_out_ready,
    input  read_num_img, read_img_size, img_index,
    input  start_reading_img_flag, start_erasing_img_flag,
    input  byte_out, byte_out_valid, busy, cmd_reject
  );
endinterface

// File: rtl/mem_reg_table_v2_byte_ser.sv
// -----------------------------------------------------------------------------
// mem_reg_byte_ser
// LSB-first byte serialiser with ready/valid output.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_data/load_len and start sending
//   load_len         : number of bytes to send (1..MAX_BYTES)
//   load_data        : value to send, byte 0 goes first
//   byte_out(_valid) : current byte, held while valid & !ready
//   byte_out_ready   : downstream accepts the byte this cycle
//   done             : last byte is being accepted this cycle
// -----------------------------------------------------------------------------
module mem_reg_byte_ser
  import mem_reg_pkg::*;
#(
  parameter int MAX_BYTES = 3,
  parameter int CNT_W     = cnt_width(MAX_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_len,
  input  logic [8*MAX_BYTES-1:0] load_data,
  output logic [7:0]             byte_out,
  output logic                   byte_out_valid,
  input  logic                   byte_out_ready,
  output logic                   done
);

  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   act_q, act_d;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    len_d = len_q;
    act_d = act_q;
    done  = 1'b0;
    if (load) begin
      buf_d = load_data;
      cnt_d = '0;
      len_d = load_len;
      act_d = 1'b1;
    end else if (act_q && byte_out_ready) begin
      if (cnt_q == len_q - 1'b1) begin
        act_d = 1'b0;
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      act_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      act_q <= act_d;
    end
  end

  // Byte is gated to zero when idle so the bus reads 0 outside a transfer.
  assign byte_out       = act_q ? buf_q[8*cnt_q +: 8] : 8'h00;
  assign byte_out_valid = act_q;

endmodule

// File: rtl/mem_reg_table_v2.sv
// -----------------------------------------------------------------------------
// mem_reg_table_v2
// Command/status register table between the SPI data buffer and the image
// memory interface. Register writes at reg_addr[3:0] = 7/8/9/A start an image
// read, count query, size query or erase. Queries fetch a value from memory
// and stream it LSB-first to SPI; read/erase wait for the matching done flag.
// Commands arriving while not IDLE are dropped with a cmd_reject pulse.
//   sysClk, rst : clock, synchronous active-high reset
//   bus         : mem_reg_table_v2_if.slave (all SPI/memory/status signals)
// Optional: define MEMREG_FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT_CYC
// cycles and answer with all-ones bytes instead of waiting forever.
// -----------------------------------------------------------------------------
module mem_reg_table_v2
  import mem_reg_pkg::*;
#(
  parameter int DATA_W      = 17,
  parameter int IDX_W       = 12,
  parameter int SIZE_BYTES  = 3,
  parameter int NUM_BYTES   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               sysClk,
  input logic               rst,
  mem_reg_table_v2_if.slave bus
);

  localparam int MAXB  = max_int(NUM_BYTES, SIZE_BYTES);
  localparam int CNT_W = cnt_width(MAXB);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] img_index_q, img_index_d;
  logic             read_num_q, read_num_d;
  logic             read_size_q, read_size_d;
  logic             start_read_q, start_read_d;
  logic             start_erase_q, start_erase_d;
  logic             reject_q, reject_d;

  logic             ser_load;
  logic [CNT_W-1:0] ser_len;
  logic [8*MAXB-1:0] ser_data;
  logic             ser_done;

  logic [3:0]       op;
  logic             cmd_valid;
  logic             tmo_hit;

  logic             unused_ok;
  assign unused_ok = ^{bus.reg_addr[7:4], bus.reg_data};

  assign op        = bus.reg_addr[3:0];
  assign cmd_valid = bus.reg_input_valid &&
                     (op == OP_READ || op == OP_NUM || op == OP_SIZE || op == OP_ERASE);

`ifdef MEMREG_FETCH_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_fetch;

  // Cleared whenever outside FETCH, so each fetch starts counting from zero.
  always_comb begin
    in_fetch = (state_q == ST_FETCH_NUM) || (state_q == ST_FETCH_SIZE);
    tmo_hit  = in_fetch && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    tmo_d    = '0;
    if (in_fetch && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge sysClk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    img_index_d   = img_index_q;
    read_num_d    = 1'b0;
    read_size_d   = 1'b0;
    start_read_d  = 1'b0;
    start_erase_d = 1'b0;
    reject_d      = 1'b0;
    ser_load      = 1'b0;
    ser_len       = '0;
    ser_data      = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          img_index_d = bus.reg_data[IDX_W-1:0];
          case (op)
            OP_NUM:   begin read_num_d    = 1'b1; state_d = ST_FETCH_NUM;  end
            OP_SIZE:  begin read_size_d   = 1'b1; state_d = ST_FETCH_SIZE; end
            OP_READ:  begin start_read_d  = 1'b1; state_d = ST_WAIT_READ;  end
            default:  begin start_erase_d = 1'b1; state_d = ST_WAIT_ERASE; end
          endcase
        end
      end
      ST_FETCH_NUM: begin
        if (bus.num_both_img_valid) begin
          ser_load             = 1'b1;
          ser_len              = CNT_W'(NUM_BYTES);
          ser_data[IDX_W-1:0]  = bus.num_both_img;
          state_d              = ST_SEND;
        end else if (tmo_hit) begin
          ser_load = 1'b1;
          ser_len  = CNT_W'(NUM_BYTES);
          ser_data = '1;
          state_d  = ST_SEND;
        end
      end
      ST_FETCH_SIZE: begin
        if (bus.jpg_size_valid) begin
          ser_load                     = 1'b1;
          ser_len                      = CNT_W'(SIZE_BYTES);
          ser_data[8*SIZE_BYTES-1:0]   = bus.jpg_size;
          state_d                      = ST_SEND;
        end else if (tmo_hit) begin
          ser_load = 1'b1;
          ser_len  = CNT_W'(SIZE_BYTES);
          ser_data = '1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_done) state_d = ST_IDLE;
      end
      ST_WAIT_READ: begin
        if (bus.done_reading_img_flag) state_d = ST_IDLE;
      end
      ST_WAIT_ERASE: begin
        if (bus.done_erasing_img_flag) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Judged on the current state: a command in the cycle the FSM heads back
    // to IDLE is still dropped.
    if (cmd_valid && state_q != ST_IDLE) reject_d = 1'b1;
  end

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      img_index_q   <= '0;
      read_num_q    <= 1'b0;
      read_size_q   <= 1'b0;
      start_read_q  <= 1'b0;
      start_erase_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      img_index_q   <= img_index_d;
      read_num_q    <= read_num_d;
      read_size_q   <= read_size_d;
      start_read_q  <= start_read_d;
      start_erase_q <= start_erase_d;
      reject_q      <= reject_d;
    end
  end

  mem_reg_byte_ser #(
    .MAX_BYTES (MAXB),
    .CNT_W     (CNT_W)
  ) u_ser (
    .clk            (sysClk),
    .rst            (rst),
    .load           (ser_load),
    .load_len       (ser_len),
    .load_data      (ser_data),
    .byte_out       (bus.byte_out),
    .byte_out_valid (bus.byte_out_valid),
    .byte_out_ready (bus.byte_out_ready),
    .done           (ser_done)
  );

  assign bus.read_num_img           = read_num_q;
  assign bus.read_img_size          = read_size_q;
  assign bus.img_index              = img_index_q;
  assign bus.start_reading_img_flag = start_read_q;
  assign bus.start_erasing_img_flag = start_erase_q;
  assign bus.cmd_reject             = reject_q;
  assign bus.busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_reg_table_v2.sv
// -----------------------------------------------------------------------------
// tb_mem_reg_table_v2
// Scoreboard bench: driver tasks issue commands, play the memory side and push
// the expected pulses/bytes into queues; a negedge monitor pops and compares.
// Define MEMREG_FETCH_TIMEOUT_EN to include the fetch-timeout scenario.
// -----------------------------------------------------------------------------
module tb_mem_reg_table_v2;
  localparam int DATA_W      = 17;
  localparam int IDX_W       = 12;
  localparam int SIZE_BYTES  = 3;
  localparam int NUM_BYTES   = 2;
  localparam int TIMEOUT_CYC = 16;

  localparam int EV_NUM    = 1;
  localparam int EV_SIZE   = 2;
  localparam int EV_READ   = 3;
  localparam int EV_ERASE  = 4;
  localparam int EV_REJECT = 5;

  typedef struct {
    int               code;
    logic [IDX_W-1:0] idx;
  } evt_t;

  logic sysClk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  evt_t       exp_evt[$];
  logic [7:0] exp_bytes[$];
  logic [IDX_W-1:0] model_idx = '0;

  int   rdy_mode   = 0;  // 0: always 1, 1: toggle, 2: random, 3: manual
  logic manual_rdy = 1'b0;

  mem_reg_table_v2_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SIZE_BYTES(SIZE_BYTES)) bus ();

  mem_reg_table_v2 #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .SIZE_BYTES(SIZE_BYTES),
    .NUM_BYTES(NUM_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sysClk (sysClk),
    .rst    (rst),
    .bus    (bus)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic push_evt(input int code);
    evt_t e;
    e.code = code;
    e.idx  = model_idx;
    exp_evt.push_back(e);
  endtask

  task automatic issue(input logic [7:0] a, input logic [DATA_W-1:0] d);
    bus.reg_addr        = a;
    bus.reg_data        = d;
    bus.reg_input_valid = 1'b1;
    tick();
    bus.reg_input_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_bytes.size() != 0 || bus.byte_out_valid || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_idle_timeout: got busy=%0b pending_bytes=%0d expected idle", name,
               bus.busy, exp_bytes.size());
    end
  endtask

  // ready generator: updates 2 time units after the edge so manual_rdy set at +1 is seen
  initial begin
    bus.byte_out_ready = 1'b0;
    forever begin
      @(posedge sysClk);
      #2;
      case (rdy_mode)
        0:       bus.byte_out_ready = 1'b1;
        1:       bus.byte_out_ready = ~bus.byte_out_ready;
        2:       bus.byte_out_ready = 1'($urandom_range(0, 1));
        default: bus.byte_out_ready = manual_rdy;
      endcase
    end
  end

  task automatic mon_pulse(input logic p, input int code, input string name);
    evt_t e;
    if (p) begin
      if (exp_evt.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_%s: got pulse expected none", name);
      end else begin
        e = exp_evt.pop_front();
        chk({"pulse_", name}, code, e.code);
        chk({"idx_at_", name}, 32'(bus.img_index), 32'(e.idx));
      end
    end
  endtask

  // monitor
  initial begin
    bit         pend = 0;
    logic [7:0] pend_byte = '0;
    logic [7:0] b;
    forever begin
      @(negedge sysClk);
      if (rst) begin
        pend = 0;
        continue;
      end
      mon_pulse(bus.read_num_img,           EV_NUM,    "read_num_img");
      mon_pulse(bus.read_img_size,          EV_SIZE,   "read_img_size");
      mon_pulse(bus.start_reading_img_flag, EV_READ,   "start_reading");
      mon_pulse(bus.start_erasing_img_flag, EV_ERASE,  "start_erasing");
      mon_pulse(bus.cmd_reject,             EV_REJECT, "cmd_reject");
      if (pend) begin
        chk("hold_valid", 32'(bus.byte_out_valid), 32'd1);
        chk("hold_byte", 32'(bus.byte_out), 32'(pend_byte));
        pend = 0;
      end
      if (bus.byte_out_valid) begin
        if (bus.byte_out_ready) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", bus.byte_out);
          end else begin
            b = exp_bytes.pop_front();
            chk("byte_out", 32'(bus.byte_out), 32'(b));
          end
        end else begin
          pend      = 1;
          pend_byte = bus.byte_out;
        end
      end
    end
  end

  task automatic op_num(input logic [3:0] hi, input logic [DATA_W-1:0] d,
                        input logic [IDX_W-1:0] cnt, input int delay, input bit inject);
    issue({hi, 4'h8}, d);
    model_idx = d[IDX_W-1:0];
    push_evt(EV_NUM);
    chk("busy_num", 32'(bus.busy), 32'd1);
    repeat (delay) tick();
    if (inject) begin
      issue({hi, 4'h9}, DATA_W'($urandom));
      push_evt(EV_REJECT);
      bus.jpg_size_valid = 1'b1;
      tick();
      bus.jpg_size_valid = 1'b0;
      chk("busy_num_stray", 32'(bus.busy), 32'd1);
    end
    for (int i = 0; i < NUM_BYTES; i++) exp_bytes.push_back(8'((32'(cnt) >> (8 * i)) & 32'hFF));
    bus.num_both_img       = cnt;
    bus.num_both_img_valid = 1'b1;
    tick();
    bus.num_both_img_valid = 1'b0;
    wait_idle("num");
  endtask

  task automatic op_size(input logic [3:0] hi, input logic [DATA_W-1:0] d,
                         input logic [8*SIZE_BYTES-1:0] sz, input int delay, input bit inject);
    issue({hi, 4'h9}, d);
    model_idx = d[IDX_W-1:0];
    push_evt(EV_SIZE);
    chk("busy_size", 32'(bus.busy), 32'd1);
    repeat (delay) tick();
    if (inject) begin
      issue({hi, 4'h8}, DATA_W'($urandom));
      push_evt(EV_REJECT);
      bus.num_both_img_valid = 1'b1;
      tick();
      bus.num_both_img_valid = 1'b0;
      chk("busy_size_stray", 32'(bus.busy), 32'd1);
    end
    for (int i = 0; i < SIZE_BYTES; i++) exp_bytes.push_back(8'((32'(sz) >> (8 * i)) & 32'hFF));
    bus.jpg_size       = sz;
    bus.jpg_size_valid = 1'b1;
    tick();
    bus.jpg_size_valid = 1'b0;
    wait_idle("size");
  endtask

  task automatic op_wait(input logic [3:0] hi, input logic [DATA_W-1:0] d, input bit is_erase,
                         input int delay, input bit inject, input bit simul);
    logic [3:0] other;
    logic [3:0] sop;
    other = is_erase ? 4'h7 : 4'hA;
    issue({hi, is_erase ? 4'hA : 4'h7}, d);
    model_idx = d[IDX_W-1:0];
    push_evt(is_erase ? EV_ERASE : EV_READ);
    chk("busy_wait", 32'(bus.busy), 32'd1);
    repeat (delay) tick();
    if (inject) begin
      issue({hi, other}, DATA_W'($urandom));
      push_evt(EV_REJECT);
      if (is_erase) bus.done_reading_img_flag = 1'b1;
      else          bus.done_erasing_img_flag = 1'b1;
      tick();
      bus.done_reading_img_flag = 1'b0;
      bus.done_erasing_img_flag = 1'b0;
      chk("busy_wrong_done", 32'(bus.busy), 32'd1);
    end
    if (is_erase) bus.done_erasing_img_flag = 1'b1;
    else          bus.done_reading_img_flag = 1'b1;
    if (simul) begin
      sop = 4'(4'h7 + 4'($urandom_range(0, 3)));
      bus.reg_addr        = {hi, sop};
      bus.reg_data        = DATA_W'($urandom);
      bus.reg_input_valid = 1'b1;
      push_evt(EV_REJECT);
    end
    tick();
    bus.reg_input_valid       = 1'b0;
    bus.done_reading_img_flag = 1'b0;
    bus.done_erasing_img_flag = 1'b0;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [3:0] hi;
    logic [3:0] nib;
    int         kind;

    rst = 1'b1;
    bus.reg_addr = '0; bus.reg_data = '0; bus.reg_input_valid = 1'b0;
    bus.num_both_img = '0; bus.num_both_img_valid = 1'b0;
    bus.jpg_size = '0; bus.jpg_size_valid = 1'b0;
    bus.done_reading_img_flag = 1'b0; bus.done_erasing_img_flag = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_read_num_img", 32'(bus.read_num_img), 32'd0);
    chk("rst_read_img_size", 32'(bus.read_img_size), 32'd0);
    chk("rst_img_index", 32'(bus.img_index), 32'd0);
    chk("rst_start_reading", 32'(bus.start_reading_img_flag), 32'd0);
    chk("rst_start_erasing", 32'(bus.start_erasing_img_flag), 32'd0);
    chk("rst_byte_out", 32'(bus.byte_out), 32'd0);
    chk("rst_byte_out_valid", 32'(bus.byte_out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmd_reject", 32'(bus.cmd_reject), 32'd0);

    // count query, ready held high
    rdy_mode = 0;
    op_num(4'h0, 17'h00000, 12'h5A3, 3, 0);

    // size query under toggling ready
    rdy_mode = 1;
    op_size(4'h0, 17'h00012, 24'h123456, 2, 0);
    chk("size_img_index", 32'(bus.img_index), 32'h012);

    // read with erase rejected mid-wait, then erase
    rdy_mode = 0;
    op_wait(4'h0, 17'h00345, 0, 2, 1, 0);
    op_wait(4'h0, 17'h00678, 1, 3, 1, 1);

    // reset in the middle of a 3-byte response
    rdy_mode   = 3;
    manual_rdy = 1'b0;
    issue(8'h09, 17'h00ABC);
    model_idx = 12'hABC;
    push_evt(EV_SIZE);
    tick();
    for (int i = 0; i < SIZE_BYTES; i++) exp_bytes.push_back(8'((32'hABCDEF >> (8 * i)) & 32'hFF));
    bus.jpg_size = 24'hABCDEF; bus.jpg_size_valid = 1'b1;
    tick();
    bus.jpg_size_valid = 1'b0;
    manual_rdy = 1'b1;
    tick();
    manual_rdy = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bytes.delete();
    model_idx = '0;
    chk("midrst_byte_out_valid", 32'(bus.byte_out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_img_index", 32'(bus.img_index), 32'd0);
    rdy_mode = 0;
    op_num(4'h0, 17'h1F0F0, 12'h0F0, 1, 0);

    // stray strobes and unrecognised codes in IDLE
    bus.jpg_size_valid = 1'b1; bus.num_both_img_valid = 1'b1;
    bus.done_reading_img_flag = 1'b1; bus.done_erasing_img_flag = 1'b1;
    tick();
    bus.jpg_size_valid = 1'b0; bus.num_both_img_valid = 1'b0;
    bus.done_reading_img_flag = 1'b0; bus.done_erasing_img_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do nib = 4'($urandom_range(0, 15)); while (nib inside {4'h7, 4'h8, 4'h9, 4'hA});
      hi = 4'($urandom_range(0, 15));
      issue({hi, nib}, DATA_W'($urandom));
    end
    tick();
    chk("stray_busy", 32'(bus.busy), 32'd0);
    chk("stray_img_index", 32'(bus.img_index), 32'(model_idx));
    chk("stray_byte_valid", 32'(bus.byte_out_valid), 32'd0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      rdy_mode = $urandom_range(0, 2);
      kind     = $urandom_range(0, 3);
      hi       = 4'($urandom_range(0, 15));
      case (kind)
        0: op_num(hi, DATA_W'($urandom), IDX_W'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        1: op_size(hi, DATA_W'($urandom), 24'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        2: op_wait(hi, DATA_W'($urandom), 0, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: op_wait(hi, DATA_W'($urandom), 1, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end

`ifdef MEMREG_FETCH_TIMEOUT_EN
    // size query with no memory answer: all-ones bytes after the timeout
    rdy_mode = 0;
    tick();
    issue(8'h09, 17'h00077);
    model_idx = 12'h077;
    push_evt(EV_SIZE);
    for (int i = 0; i < SIZE_BYTES; i++) exp_bytes.push_back(8'hFF);
    wait_idle("timeout");
`endif

    repeat (5) tick();
    chk("leftover_events", 32'(exp_evt.size()), 32'd0);
    chk("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
